// File: rtl/xadc_drp_responder_if.sv
// DRP bus between a DRP master and the XADC responder model.
interface xadc_drp_responder_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (
    output DADDR,
    output DEN,
    output DWE,
    output DI,
    input  DO,
    input  DRDY
  );

  modport slave (
    input  DADDR,
    input  DEN,
    input  DWE,
    input  DI,
    output DO,
    output DRDY
  );
endinterface

// File: rtl/xadc_drp_responder.sv
// Behavioural XADC DRP responder: fixed-latency DRP slave plus a 4-channel aux sequencer.
// Optional macro XADC_RESP_AVG_EN stores a running two-point average instead of raw samples.
module xadc_drp_responder #(
  parameter int unsigned RD_LATENCY  = 3,
  parameter int unsigned CONV_CYCLES = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  xadc_drp_responder_if.slave  drp,
  output logic                 BUSY,
  output logic                 EOS,
  output logic [4:0]           MUXADDR,
  input  logic [11:0]          SAMPLE0,
  input  logic [11:0]          SAMPLE1,
  input  logic [11:0]          SAMPLE2,
  input  logic [11:0]          SAMPLE3
);

  localparam logic [3:0] LatInit  = 4'(RD_LATENCY - 1);
  localparam logic [7:0] ConvLast = 8'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StConvert, StStore} state_e;

  state_e      state_q, state_d;
  logic        pending_q;
  logic [3:0]  lat_q;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q;
  logic [15:0] cfg_q [16];
  logic [11:0] result_q [4];
  logic [1:0]  ch_q, ch_d;
  logic [7:0]  conv_q, conv_d;
  logic        eos_q;
  logic        drdy, accept, cfg_wr, cont_mode, store_en;
  logic [15:0] rdata;
  logic [11:0] samples [4];
  logic [11:0] new_result;

  function automatic logic [15:0] cfg_reset(input logic [3:0] idx);
    case (idx)
      4'h0:             return 16'hB903;
      4'h1:             return 16'h20F0;
      4'h2:             return 16'h3F00;
      4'h9, 4'hB, 4'hF: return 16'h000F;
      default:          return 16'h0000;
    endcase
  endfunction

  assign drdy   = pending_q && (lat_q == 4'd0);
  assign accept = drp.DEN && (!pending_q || drdy);
  assign cfg_wr = drdy && we_q && (addr_q[6:4] == 3'b100);
  // Look through a same-cycle write to 0x41 so the sequencer reacts on the DRDY cycle itself.
  assign cont_mode = (cfg_wr && addr_q[3:0] == 4'h1) ? (di_q[15:12] == 4'h2)
                                                     : (cfg_q[1][15:12] == 4'h2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      lat_q     <= 4'd0;
      addr_q    <= 7'd0;
      we_q      <= 1'b0;
      di_q      <= 16'h0000;
    end else if (accept) begin
      pending_q <= 1'b1;
      lat_q     <= LatInit;
      addr_q    <= drp.DADDR;
      we_q      <= drp.DWE;
      di_q      <= drp.DI;
    end else if (drdy) begin
      pending_q <= 1'b0;
    end else if (pending_q) begin
      lat_q     <= lat_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cfg_q[i] <= cfg_reset(4'(i));
    end else if (cfg_wr) begin
      cfg_q[addr_q[3:0]] <= di_q;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (addr_q[6:2] == 5'b00100) begin
      rdata = {result_q[addr_q[1:0]], 4'h0};
    end else if (addr_q[6:4] == 3'b100) begin
      rdata = cfg_q[addr_q[3:0]];
    end
  end

  assign drp.DO   = drdy ? rdata : 16'h0000;
  assign drp.DRDY = drdy;

  always_comb begin
    state_d  = state_q;
    conv_d   = conv_q;
    ch_d     = ch_q;
    store_en = 1'b0;
    case (state_q)
      StIdle: begin
        if (cont_mode) begin
          state_d = StConvert;
          conv_d  = 8'd0;
          ch_d    = 2'd0;
        end
      end
      StConvert: begin
        if (conv_q == ConvLast) state_d = StStore;
        else                    conv_d  = conv_q + 8'd1;
      end
      StStore: begin
        store_en = 1'b1;
        ch_d     = ch_q + 2'd1;
        conv_d   = 8'd0;
        state_d  = cont_mode ? StConvert : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      conv_q  <= 8'd0;
      ch_q    <= 2'd0;
      eos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      conv_q  <= conv_d;
      ch_q    <= ch_d;
      eos_q   <= store_en && (ch_q == 2'd3);
    end
  end

  assign samples[0] = SAMPLE0;
  assign samples[1] = SAMPLE1;
  assign samples[2] = SAMPLE2;
  assign samples[3] = SAMPLE3;

`ifdef XADC_RESP_AVG_EN
  logic [12:0] avg_sum;
  assign avg_sum    = {1'b0, result_q[ch_q]} + {1'b0, samples[ch_q]};
  assign new_result = avg_sum[12:1];
`else
  assign new_result = samples[ch_q];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) result_q[i] <= 12'h000;
    end else if (store_en) begin
      result_q[ch_q] <= new_result;
    end
  end

  assign BUSY    = (state_q == StConvert);
  assign EOS     = eos_q;
  assign MUXADDR = {3'b000, ch_q};

endmodule

// File: doc/xadc_drp_responder.md
XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 3, meaning cycles from DEN accept to DRDY (legal 1..15).
REQ-002 SHALL have parameter CONV_CYCLES, default 26, meaning cycles per channel conversion (legal 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port DADDR  input  7  DRP register address, sampled with DEN.
REQ-006 SHALL have port DEN  input  1  DRP transaction strobe, one-cycle pulse.
REQ-007 SHALL have port DWE  input  1  DRP write enable, sampled with DEN.
REQ-008 SHALL have port DI  input  16  DRP write data, sampled with DEN.
REQ-009 SHALL have port DO  output  16  DRP read data, valid only while DRDY is high, else 16'h0000.
REQ-010 SHALL have port DRDY  output  1  one-cycle transaction-complete pulse.
REQ-011 SHALL have port BUSY  output  1  high while a conversion is in progress.
REQ-012 SHALL have port EOS  output  1  one-cycle end-of-sequence pulse.
REQ-013 SHALL have port MUXADDR  output  5  external mux channel select, {3'b000, ch[1:0]}.
REQ-014 SHALL have ports SAMPLE0..SAMPLE3  input  12 each  analog sample value of aux channel 0..3.

Function
REQ-015 SHALL map reads: 0x10+n (n=0..3) return {result_n[11:0],4'h0}; 0x40..0x4F return the config register; all other addresses return 16'h0000.
REQ-016 SHALL write DI to config register 0x40..0x4F when DWE=1; writes to any other address SHALL be discarded but still complete with DRDY.
REQ-017 SHALL latch DADDR/DWE/DI on the DEN cycle and pulse DRDY exactly RD_LATENCY cycles later; the write SHALL take effect on the DRDY cycle, and read data SHALL be taken from register state at the start of the DRDY cycle.
REQ-018 SHALL ignore DEN asserted while a transaction is pending (no second DRDY, no latch update).
REQ-019 SHALL accept a new DEN on the same cycle DRDY is asserted.
REQ-020 SHALL run the sequencer FSM IDLE->CONVERT->STORE->(CONVERT or IDLE) when config 0x41 bits[15:12]==4'h2 (continuous mode); other values SHALL return to IDLE after the current STORE.
REQ-021 SHALL hold BUSY=1 for exactly CONV_CYCLES cycles in CONVERT, with MUXADDR equal to the channel being converted.
REQ-022 SHALL, in STORE (one cycle, BUSY=0), capture SAMPLEch into result_ch and advance ch modulo 4.
REQ-023 SHALL pulse EOS in the cycle after the STORE of channel 3, coincident with the next CONVERT start when in continuous mode.
REQ-024 SHALL return a read of result_n whose STORE occurs on the DRDY cycle with the pre-store value.
REQ-025 SHALL restart at channel 0 when a write to 0x41 enters continuous mode from IDLE, with CONVERT starting the cycle after the DRDY cycle.

Reset
REQ-026 SHALL on rst force DO=0, DRDY=0, BUSY=0, EOS=0, MUXADDR=0, ch=0, FSM=IDLE, pending transaction cleared, result_0..3=12'h000.
REQ-027 SHALL reset config registers to 0x40=16'hB903, 0x41=16'h20F0, 0x42=16'h3F00, 0x49=16'h000F, 0x4B=16'h000F, 0x4F=16'h000F, all others 16'h0000.
REQ-028 SHALL leave IDLE for CONVERT on the first clock after rst deasserts, since reset mode is continuous.
REQ-029 SHALL drop a transaction in progress when rst asserts mid-transaction, with no DRDY produced.

Configuration
REQ-030 SHALL, with macro XADC_RESP_AVG_EN defined, store result_ch = (result_ch + SAMPLEch) >> 1 using a 13-bit sum, truncated.
REQ-031 SHALL, without XADC_RESP_AVG_EN, store SAMPLEch directly.

Verification
REQ-032 SHALL cover: reset, read 0x41 -> DRDY 3 cycles after DEN, DO=16'h20F0.
REQ-033 SHALL cover: SAMPLE0..3=12'hABC/123/FFF/000, wait for EOS, read 0x10..0x13 -> 16'hABC0/1230/FFF0/0000; MUXADDR steps 0,1,2,3 at 27-cycle spacing.
REQ-034 SHALL cover: write 0x41=16'h0000 -> sequencer finishes current STORE, BUSY stays 0, EOS absent; write 16'h20F0 -> CONVERT on ch0 the cycle after DRDY.
REQ-035 SHALL cover: DEN at cycles t and t+1 -> exactly one DRDY at t+3; DEN at t+3 accepted -> DRDY at t+6.
REQ-036 SHALL cover: write 0x10=16'h5555 -> DRDY pulses, read back returns the last stored sample, not 16'h5555.
REQ-037 SHALL cover: with XADC_RESP_AVG_EN, SAMPLE0=12'h800 after reset -> first result 12'h400, second 12'h600.
